// File: rtl/tdc_spi_txn_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : tdc_spi_txn_ctrl_if
// Description : Bundle of the two requester ports and the byte-level SPI
//               master connection used by tdc_spi_txn_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
interface tdc_spi_txn_ctrl_if;
  // Port A: configuration writes
  logic        a_req;
  logic [7:0]  a_opcode;
  logic [2:0]  a_len;
  logic [31:0] a_wdata;
  logic        a_done;
  logic [31:0] a_rdata;
  // Port B: result reads
  logic        b_req;
  logic [7:0]  b_opcode;
  logic [2:0]  b_len;
  logic [31:0] b_wdata;
  logic        b_done;
  logic [31:0] b_rdata;
  // Shared error pulse
  logic        err;
  // Byte-level SPI master
  logic        spi_start;
  logic [7:0]  spi_data_in;
  logic        spi_cs_end;
  logic        spi_busy;
  logic        spi_new_data;
  logic [7:0]  spi_data_out;

  // Transaction controller side
  modport slave (
    input  a_req, a_opcode, a_len, a_wdata,
    input  b_req, b_opcode, b_len, b_wdata,
    input  spi_busy, spi_new_data, spi_data_out,
    output a_done, a_rdata, b_done, b_rdata, err,
    output spi_start, spi_data_in, spi_cs_end
  );

  // Environment side: requesters plus SPI master
  modport master (
    output a_req, a_opcode, a_len, a_wdata,
    output b_req, b_opcode, b_len, b_wdata,
    output spi_busy, spi_new_data, spi_data_out,
    input  a_done, a_rdata, b_done, b_rdata, err,
    input  spi_start, spi_data_in, spi_cs_end
  );
endinterface
`default_nettype wire

// File: rtl/tdc_spi_txn_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tdc_spi_txn_ctrl
// Description : Round-robin transaction sequencer for the TDC SPI master.
//               Sends opcode + 0..4 data bytes in one CS frame, collects the
//               read-back bytes and pulses done (and err on timeout).
// Revision    : 1.0 - initial release
// ============================================================================
module tdc_spi_txn_ctrl #(
  parameter int TIMEOUT = 1024,
  parameter int TO_W    = 11
) (
  input wire clk,
  input wire rst,
  tdc_spi_txn_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam logic [TO_W-1:0] c_timeout = TO_W'(TIMEOUT);
  localparam logic [TO_W-1:0] c_to_one  = TO_W'(1);

  state_t          r_state;
  state_t          w_state_nxt;
  logic            r_last_grant;   // 1 = port B served last
  logic            r_grant;        // 1 = port B owns the current transaction
  logic [7:0]      r_opcode;
  logic [2:0]      r_len;
  logic [31:0]     r_wdata;
  logic [2:0]      r_remaining;    // bytes still to complete, opcode included
  logic [31:0]     r_shift;
  logic [TO_W-1:0] r_to_cnt;
  logic            r_err;
  logic [7:0]      r_data_in;
  logic            r_cs_end;
  logic [31:0]     r_a_rdata;
  logic [31:0]     r_b_rdata;

  logic            w_gnt_any;
  logic            w_gnt_b;
  logic [2:0]      w_sel_len;
  logic [2:0]      w_len_clamp;
  logic            w_is_opcode;
  logic            w_last;
  logic            w_timeout;
  logic [7:0]      w_byte;
  logic            w_start;
  logic [7:0]      w_data_in;
  logic            w_cs_end;
  logic            w_a_done;
  logic            w_b_done;
  logic            w_err;
  logic [31:0]     w_a_rdata;
  logic [31:0]     w_b_rdata;

  // A grant needs an idle master; on a tie the port not served last wins.
  assign w_gnt_any   = ~bus.spi_busy & (bus.a_req | bus.b_req);
  assign w_gnt_b     = bus.b_req & (~bus.a_req | ~r_last_grant);
  assign w_sel_len   = w_gnt_b ? bus.b_len : bus.a_len;
  assign w_len_clamp = (w_sel_len > 3'd4) ? 3'd4 : w_sel_len;

  // The opcode is the byte in flight while nothing has been consumed yet.
  assign w_is_opcode = (r_remaining == (r_len + 3'd1));
  assign w_last      = (r_remaining == 3'd1);
  assign w_timeout   = (r_to_cnt == c_timeout);

  // Byte to send: opcode first, then wdata MSB-first indexed by bytes left.
  always_comb begin
    w_byte = r_opcode;
    if (!w_is_opcode) begin
      case (r_remaining)
        3'd1:    w_byte = r_wdata[7:0];
        3'd2:    w_byte = r_wdata[15:8];
        3'd3:    w_byte = r_wdata[23:16];
        3'd4:    w_byte = r_wdata[31:24];
        default: w_byte = r_opcode;
      endcase
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and output decode; data_in/cs_end hold their issued values.
  always_comb begin
    w_state_nxt = r_state;
    w_start     = 1'b0;
    w_data_in   = r_data_in;
    w_cs_end    = r_cs_end;
    w_a_done    = 1'b0;
    w_b_done    = 1'b0;
    w_err       = 1'b0;
    w_a_rdata   = r_a_rdata;
    w_b_rdata   = r_b_rdata;
    case (r_state)
      ST_IDLE: begin
        if (w_gnt_any) begin
          w_state_nxt = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        w_start     = 1'b1;
        w_data_in   = w_byte;
        w_cs_end    = w_last;
        w_state_nxt = ST_WAIT;
      end
      ST_WAIT: begin
        if (bus.spi_new_data) begin
          w_state_nxt = w_last ? ST_DONE : ST_ISSUE;
        end else if (w_timeout) begin
          w_state_nxt = ST_DONE;
        end
      end
      ST_DONE: begin
        w_err = r_err;
        if (r_grant) begin
          w_b_done  = 1'b1;
          w_b_rdata = r_shift;
        end else begin
          w_a_done  = 1'b1;
          w_a_rdata = r_shift;
        end
        w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Transaction datapath: latched request, byte count, timeout, read-back.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_last_grant <= 1'b1;
      r_grant      <= 1'b0;
      r_opcode     <= 8'd0;
      r_len        <= 3'd0;
      r_wdata      <= 32'd0;
      r_remaining  <= 3'd0;
      r_shift      <= 32'd0;
      r_to_cnt     <= '0;
      r_err        <= 1'b0;
      r_data_in    <= 8'd0;
      r_cs_end     <= 1'b0;
      r_a_rdata    <= 32'd0;
      r_b_rdata    <= 32'd0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_gnt_any) begin
            r_grant     <= w_gnt_b;
            r_opcode    <= w_gnt_b ? bus.b_opcode : bus.a_opcode;
            r_wdata     <= w_gnt_b ? bus.b_wdata : bus.a_wdata;
            r_len       <= w_len_clamp;
            r_remaining <= w_len_clamp + 3'd1;
            r_shift     <= 32'd0;
            r_err       <= 1'b0;
          end
        end
        ST_ISSUE: begin
          r_data_in <= w_byte;
          r_cs_end  <= w_last;
          r_to_cnt  <= '0;
        end
        ST_WAIT: begin
          r_to_cnt <= r_to_cnt + c_to_one;
          if (bus.spi_new_data) begin
            r_remaining <= r_remaining - 3'd1;
            if (!w_is_opcode) begin
              r_shift <= {r_shift[23:0], bus.spi_data_out};
            end
          end else if (w_timeout) begin
            r_err <= 1'b1;
          end
        end
        ST_DONE: begin
          r_last_grant <= r_grant;
          r_err        <= 1'b0;
          if (r_grant) begin
            r_b_rdata <= r_shift;
          end else begin
            r_a_rdata <= r_shift;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.spi_start   = w_start;
  assign bus.spi_data_in = w_data_in;
  assign bus.spi_cs_end  = w_cs_end;
  assign bus.a_done      = w_a_done;
  assign bus.b_done      = w_b_done;
  assign bus.err         = w_err;
  assign bus.a_rdata     = w_a_rdata;
  assign bus.b_rdata     = w_b_rdata;

endmodule
`default_nettype wire

// File: doc/tdc_spi_txn_ctrl.md
Name: tdc_spi_txn_ctrl

Overview:
- Transaction sequencer in front of the byte-level TDC SPI master.
- Two requesters share the SPI link: port A (configuration writes) and port B (result reads). Each request is one opcode byte followed by 0-4 data bytes, all under a single CS frame.
- Arbitrates between the ports, feeds bytes to the master one at a time, drives the master's CS_END on the last byte, and collects the read-back bytes.

Parameters:
- TIMEOUT, 1024: maximum clk cycles to wait for spi_new_data after a byte start before aborting.
- TO_W, 11: width of the timeout counter; must satisfy 2^TO_W > TIMEOUT.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- a_req  in  1  port A request; held high until a_done.
- a_opcode  in  8  port A opcode byte.
- a_len  in  3  port A data byte count, 0..4; values 5-7 are treated as 4.
- a_wdata  in  32  port A write data, right-aligned, MSB byte sent first.
- a_done  out  1  one-cycle pulse: port A transaction finished.
- a_rdata  out  32  port A read-back, right-aligned; valid with a_done.
- b_req, b_opcode, b_len, b_wdata, b_done, b_rdata: same as port A, for port B.
- err  out  1  one-cycle pulse coincident with a done pulse on timeout.
- spi_start  out  1  to master start.
- spi_data_in  out  8  to master data_in.
- spi_cs_end  out  1  to master CS_END.
- spi_busy  in  1  from master busy.
- spi_new_data  in  1  from master new_data.
- spi_data_out  in  8  from master data_out.

Behaviour:
- Reset: all outputs 0, state IDLE, last_grant=B (so A wins the first tie), byte counter 0, rdata shift register 0.
- States: IDLE -> ISSUE -> WAIT -> (ISSUE | DONE) -> IDLE.
- IDLE:
  - If spi_busy=1, no grant is issued.
  - Otherwise, if any req is high, grant it. When both are high, grant the port not in last_grant (round-robin).
  - Latch the granted port's opcode, len (clamped to 4) and wdata. Set remaining = len + 1. Go to ISSUE.
- ISSUE (exactly one cycle):
  - spi_start=1.
  - spi_data_in = the opcode for the first byte; after that, the next wdata byte MSB-first, i.e. wdata[8*k-1 -: 8] with k counting down from len.
  - spi_cs_end = 1 if remaining==1.
  - Go to WAIT and clear the timeout counter.
- WAIT:
  - spi_data_in and spi_cs_end are held stable throughout. The master samples them late in the byte.
  - On spi_new_data: decrement remaining. If the completed byte was not the opcode, shift it in: rdata = {rdata[23:0], spi_data_out}. If remaining==0 go to DONE, else go to ISSUE.
  - Timeout counter increments each WAIT cycle. On reaching TIMEOUT, set the error flag and go to DONE.
- DONE (one cycle):
  - Pulse the granted port's done; pulse err with it if the error flag is set.
  - Drive the port's rdata from the shift register. rdata holds until that port's next done.
  - Update last_grant, clear the error flag, go to IDLE.
- Received data:
  - The byte received during the opcode is discarded.
  - For len<4, the upper rdata bytes are 0 (shift register cleared at grant).
- Latency, clk cycles:
  - Grant: 1 after req in IDLE.
  - Between bytes: 1 cycle from spi_new_data to the next spi_start.
  - Done: 1 cycle after the final spi_new_data.
- Request rules:
  - A req dropped mid-transaction is ignored; the transaction completes.
  - A req still high in the cycle after done is treated as a new request.
- Timeout:
  - The master may still be active after a timeout.
  - IDLE blocks new grants until spi_busy=0.
  - spi_cs_end stays at its last value until the next ISSUE.
- spi_new_data outside WAIT is ignored.
- Reset mid-transaction returns to IDLE immediately with no done pulse. The master shares rst.

Test Plan:
- A only, opcode 0x80, len 3, wdata 0x00_123456 -> bytes 0x80, 0x12, 0x34, 0x56 with spi_cs_end=1 only on 0x56; a_done one cycle after the 4th spi_new_data; err=0.
- B only, opcode 0xB0, len 4, master model returns 0xFF, 0xDE, 0xAD, 0xBE, 0xEF -> b_rdata=0xDEADBEEF on b_done.
- A and B asserted in the same cycle, both held -> A served first, then B, then A (round-robin); no overlap of CS frames.
- len 0, opcode 0x70 (reset opcode) -> single byte with spi_cs_end=1; done pulse; rdata=0.
- Model never returns spi_new_data -> err and done pulse exactly TIMEOUT+2 cycles after spi_start; no new grant while spi_busy=1.
- rst asserted during the 2nd byte of a 4-byte read -> outputs 0 next cycle, no done pulse, next request served normally.
